// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier arbiter: FSM state encoding and
// default sizing for operands, requesters and multiplier latency.
package mul_pkg;

  localparam int DEF_NUM_BITS   = 7;
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_MUL_CYCLES = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } mul_state_t;

  // Width of an index able to address n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: scans requests starting just after the
// last granted requester and returns the first hit as one-hot plus index.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_granted,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               valid
);

  logic [IDX_W-1:0] cand;

  // The last granted requester is visited last, so nobody can be starved.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    cand      = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((int'(last_granted) + off) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one external multi-cycle multiplier core between several requesters,
// sequencing clear, launch, wait and result capture for one job at a time.
module mul_arbiter
  import mul_pkg::*;
#(
  parameter int NUM_BITS   = DEF_NUM_BITS,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int MUL_CYCLES = DEF_MUL_CYCLES
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*NUM_BITS-1:0]  op_a,
  input  logic [NUM_REQ*NUM_BITS-1:0]  op_b,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           done,
  output logic [2*NUM_BITS-1:0]        result,
  output logic                         busy,
  output logic                         mul_rst,
  output logic                         mul_start,
  output logic [NUM_BITS-1:0]          mul_multiplier,
  output logic [NUM_BITS-1:0]          mul_multiplicand,
  input  logic [2*NUM_BITS-1:0]        mul_product
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = idx_width(MUL_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  mul_state_t state, state_nxt;

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    last_granted;
  logic [IDX_W-1:0]    pick_idx;
  logic [NUM_REQ-1:0]  pick_grant;
  logic                pick_valid;
  logic [NUM_BITS-1:0] a_slice [NUM_REQ];
  logic [NUM_BITS-1:0] b_slice [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_slice[g] = op_a[g*NUM_BITS +: NUM_BITS];
    assign b_slice[g] = op_b[g*NUM_BITS +: NUM_BITS];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req          (req),
    .last_granted (last_granted),
    .grant        (pick_grant),
    .grant_idx    (pick_idx),
    .valid        (pick_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The core is held in reset whenever the arbiter itself is in reset.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    mul_rst   = !rst_n;
    mul_start = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (pick_valid) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        mul_rst   = 1'b1;
        state_nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
        mul_start = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (cnt == '0) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Loaded while launching so WAIT lasts exactly MUL_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == S_LAUNCH) begin
      cnt <= CNT_LOAD;
    end else if (state == S_WAIT && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // last_granted doubles as the owner of the job in flight for the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant            <= '0;
      done             <= '0;
      result           <= '0;
      last_granted     <= IDX_LAST;
      mul_multiplier   <= '0;
      mul_multiplicand <= '0;
    end else begin
      grant <= '0;
      done  <= '0;
      if (state == S_IDLE && pick_valid) begin
        grant            <= pick_grant;
        last_granted     <= pick_idx;
        mul_multiplier   <= a_slice[pick_idx];
        mul_multiplicand <= b_slice[pick_idx];
      end
      if (state == S_DONE) begin
        done   <= ONE_HOT0 << last_granted;
        result <= mul_product;
      end
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter with a behavioural multiplier core and a
// round-robin reference model driving directed and randomized jobs.
module tb_mul_arbiter;

  localparam int NB = 7;
  localparam int NR = 4;
  localparam int MC = 16;
  localparam int PW = 2 * NB;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req;
  logic [NR*NB-1:0] op_a;
  logic [NR*NB-1:0] op_b;
  logic [NR-1:0]    grant;
  logic [NR-1:0]    done;
  logic [PW-1:0]    result;
  logic             busy;
  logic             mul_rst;
  logic             mul_start;
  logic [NB-1:0]    mul_multiplier;
  logic [NB-1:0]    mul_multiplicand;
  logic [PW-1:0]    mul_product;

  logic [4:0]       core_cnt;
  logic [NB-1:0]    core_a;
  logic [NB-1:0]    core_b;

  int               checks = 0;
  int               errors = 0;
  int               last_model;
  logic [NR-1:0]    req_drv;
  int               opa [NR];
  int               opb [NR];
  logic [PW-1:0]    prev_result;

  always #5 clk = ~clk;

  mul_arbiter #(
    .NUM_BITS   (NB),
    .NUM_REQ    (NR),
    .MUL_CYCLES (MC)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req              (req),
    .op_a             (op_a),
    .op_b             (op_b),
    .grant            (grant),
    .done             (done),
    .result           (result),
    .busy             (busy),
    .mul_rst          (mul_rst),
    .mul_start        (mul_start),
    .mul_multiplier   (mul_multiplier),
    .mul_multiplicand (mul_multiplicand),
    .mul_product      (mul_product)
  );

  // Shared core: product appears MC cycles after the start pulse is high.
  always @(posedge clk) begin
    if (mul_rst) begin
      core_cnt    <= '0;
      mul_product <= '0;
    end else if (mul_start) begin
      core_cnt    <= 5'(MC - 1);
      core_a      <= mul_multiplier;
      core_b      <= mul_multiplicand;
      mul_product <= '0;
    end else if (core_cnt != '0) begin
      core_cnt <= core_cnt - 5'd1;
      if (core_cnt == 5'd1) mul_product <= PW'(core_a) * PW'(core_b);
    end
  end

  task automatic applyStimulus();
    req = req_drv;
    for (int i = 0; i < NR; i++) begin
      op_a[i*NB +: NB] = NB'(opa[i]);
      op_b[i*NB +: NB] = NB'(opb[i]);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int rrModel(input logic [NR-1:0] r, input int last);
    logic [1:0] j;
    for (int k = 1; k <= NR; k++) begin
      j = 2'((last + k) % NR);
      if (r[j]) return int'(j);
    end
    return 0;
  endfunction

  // One full job from the grant edge to the done edge, starting in IDLE.
  task automatic runJob(input int idx, input int prod, input bit reraise);
    logic [NR-1:0] oh;
    logic          quiet;
    oh = 4'b0001 << idx;
    @(posedge clk); #1;
    checkOutput("grant", 32'(grant), 32'(oh));
    checkOutput("mul_multiplier", 32'(mul_multiplier), 32'(opa[idx]));
    checkOutput("mul_multiplicand", 32'(mul_multiplicand), 32'(opb[idx]));
    checkOutput("clear_rst_busy_start", 32'({mul_rst, busy, mul_start}), 32'(3'b110));
    req_drv[idx] = 1'b0;
    applyStimulus();
    @(posedge clk); #1;
    checkOutput("launch_rst_start", 32'({mul_rst, mul_start, grant}), 32'(6'b010000));
    quiet = 1'b1;
    for (int c = 0; c < MC + 1; c++) begin
      @(posedge clk); #1;
      if (done != '0 || grant != '0 || mul_start || mul_rst || !busy || result !== prev_result)
        quiet = 1'b0;
    end
    checkOutput("quiet_wait", 32'(quiet), 32'(1));
    @(posedge clk); #1;
    checkOutput("done", 32'(done), 32'(oh));
    checkOutput("result", 32'(result), 32'(prod));
    checkOutput("no_grant_with_done", 32'(grant), 32'(0));
    checkOutput("idle_busy", 32'(busy), 32'(0));
    prev_result = PW'(prod);
    last_model  = idx;
    if (reraise) begin
      req_drv[idx] = 1'b1;
      applyStimulus();
    end
  endtask

  task automatic doReset();
    rst_n   = 1'b0;
    req_drv = '0;
    applyStimulus();
    repeat (2) @(posedge clk);
    #1;
    rst_n       = 1'b1;
    last_model  = NR - 1;
    prev_result = '0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int idx;
    logic quiet;
    rst_n   = 1'b0;
    req_drv = '0;
    for (int i = 0; i < NR; i++) begin
      opa[i] = 0;
      opb[i] = 0;
    end
    applyStimulus();
    #1;
    checkOutput("reset_outputs", 32'({grant, done, busy, mul_start}), 32'(0));
    checkOutput("reset_result", 32'(result), 32'(0));
    checkOutput("reset_operands", 32'({mul_multiplier, mul_multiplicand}), 32'(0));
    checkOutput("reset_mul_rst", 32'(mul_rst), 32'(1));
    repeat (3) @(posedge clk);
    #1;
    rst_n       = 1'b1;
    last_model  = NR - 1;
    prev_result = '0;

    $display("[TB] single request 3x5");
    opa[0] = 3; opb[0] = 5; req_drv = 4'b0001;
    applyStimulus();
    runJob(0, 15, 1'b0);

    $display("[TB] all four requesters after reset");
    doReset();
    opa[0] = 15; opb[0] = 15;
    opa[1] = 0;  opb[1] = 12;
    opa[2] = 1;  opb[2] = 2;
    opa[3] = 92; opb[3] = 75;
    req_drv = 4'b1111;
    applyStimulus();
    runJob(0, 225, 1'b0);
    runJob(1, 0, 1'b0);
    runJob(2, 2, 1'b0);
    runJob(3, 6900, 1'b0);

    $display("[TB] full-scale operands");
    opa[0] = 127; opb[0] = 127; req_drv = 4'b0001;
    applyStimulus();
    runJob(0, 16129, 1'b0);

    $display("[TB] two requesters re-raising");
    opa[1] = 9;  opb[1] = 10;
    opa[3] = 11; opb[3] = 12;
    req_drv = 4'b1010;
    applyStimulus();
    runJob(1, 90, 1'b1);
    runJob(3, 132, 1'b1);
    runJob(1, 90, 1'b0);
    runJob(3, 132, 1'b0);

    $display("[TB] randomized jobs");
    for (int n = 0; n < 10; n++) begin
      if (req_drv == '0) req_drv = 4'($urandom_range(1, 15));
      else req_drv = req_drv | 4'($urandom_range(0, 15));
      for (int i = 0; i < NR; i++) begin
        opa[i] = int'($urandom_range(0, 127));
        opb[i] = int'($urandom_range(0, 127));
      end
      applyStimulus();
      idx = rrModel(req_drv, last_model);
      runJob(idx, opa[idx] * opb[idx], 1'b0);
    end

    $display("[TB] reset during WAIT");
    opa[0] = 5; opb[0] = 6;
    opa[2] = 7; opb[2] = 8;
    req_drv = 4'b0001;
    applyStimulus();
    @(posedge clk); #1;
    checkOutput("grant_before_abort", 32'(grant), 32'(4'b0001));
    req_drv = '0;
    applyStimulus();
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_outputs", 32'({grant, done, busy, mul_start}), 32'(0));
    checkOutput("abort_result", 32'(result), 32'(0));
    checkOutput("abort_operands", 32'({mul_multiplier, mul_multiplicand}), 32'(0));
    checkOutput("abort_mul_rst", 32'(mul_rst), 32'(1));
    req_drv = 4'b0101;
    applyStimulus();
    quiet = 1'b1;
    for (int c = 0; c < MC + 4; c++) begin
      @(posedge clk); #1;
      if (done != '0 || grant != '0) quiet = 1'b0;
    end
    checkOutput("abort_no_done", 32'(quiet), 32'(1));
    rst_n       = 1'b1;
    last_model  = NR - 1;
    prev_result = '0;
    runJob(0, 30, 1'b0);
    runJob(2, 56, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_BITS, default 7, operand width in bits.
REQ-002 The block SHALL have parameter NUM_REQ, default 4, number of requesters.
REQ-003 The block SHALL have parameter MUL_CYCLES, default 16, clock cycles from mul_start high to mul_product valid.
REQ-004 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port req  input  NUM_REQ  per-requester request level.
REQ-007 The block SHALL have port op_a  input  NUM_REQ*NUM_BITS  packed multiplier operands; requester i in slice i.
REQ-008 The block SHALL have port op_b  input  NUM_REQ*NUM_BITS  packed multiplicand operands; requester i in slice i.
REQ-009 The block SHALL have port grant  output  NUM_REQ  one-hot pulse marking the cycle in which operands are captured.
REQ-010 The block SHALL have port done  output  NUM_REQ  one-hot pulse marking result valid for that requester.
REQ-011 The block SHALL have port result  output  2*NUM_BITS  last completed product, held until the next done.
REQ-012 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 The block SHALL have port mul_rst  output  1  active-high reset to the shared multiplier core.
REQ-014 The block SHALL have port mul_start  output  1  start pulse to the shared multiplier core.
REQ-015 The block SHALL have ports mul_multiplier and mul_multiplicand  output  NUM_BITS each  registered operands of the job in flight.
REQ-016 The block SHALL have port mul_product  input  2*NUM_BITS  product returned by the core.

Function
REQ-017 The FSM SHALL have states IDLE, CLEAR, LAUNCH, WAIT and DONE.
REQ-018 The FSM SHALL sequence IDLE (any req high) -> CLEAR -> LAUNCH -> WAIT (MUL_CYCLES cycles) -> DONE -> IDLE; IDLE with no req stays in IDLE.
REQ-019 In the IDLE cycle that leaves IDLE, the block SHALL assert exactly one grant bit and register that requester's op_a and op_b into mul_multiplier and mul_multiplicand.
REQ-020 Arbitration SHALL be round-robin: the search starts at last_granted+1 modulo NUM_REQ, and last_granted updates on each grant.
REQ-021 mul_rst SHALL be high only in CLEAR; mul_start SHALL be high only in LAUNCH.
REQ-022 A down-counter loaded with MUL_CYCLES-1 on entry to WAIT SHALL exit WAIT when it reaches 0.
REQ-023 In DONE, the block SHALL register mul_product into result and pulse the done bit of the granted requester for one cycle.
REQ-024 done SHALL occur exactly MUL_CYCLES+3 cycles after its grant; job spacing SHALL be MUL_CYCLES+4 cycles.
REQ-025 A requester SHALL drop req before the FSM returns to IDLE; a req still high in IDLE SHALL count as a new request.
REQ-026 Deasserting req mid-job SHALL NOT abort the job; done SHALL still pulse.
REQ-027 grant and done SHALL never be high in the same cycle; the earliest next grant is the cycle after DONE.
REQ-028 result width SHALL be 2*NUM_BITS with no truncation.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE and the counter to 0.
REQ-030 rst_n low SHALL force grant, done, result, busy, mul_start, mul_multiplier and mul_multiplicand to 0.
REQ-031 rst_n low SHALL force mul_rst to 1 so the core is held in reset.
REQ-032 rst_n low SHALL set last_granted to NUM_REQ-1, so requester 0 wins first.
REQ-033 Reset mid-job SHALL discard the job with no done pulse.

Structure
REQ-034 State encoding and the default values of NUM_BITS and MUL_CYCLES SHALL live in shared package mul_pkg.
REQ-035 Round-robin selection SHALL be the sub-module rr_pick, combinational: inputs req and last_granted, outputs a one-hot grant and its index.
REQ-036 The multiplier core SHALL sit outside this block; the bench instantiates it alongside.

Verification
REQ-037 req[0] with 3x5 -> grant[0] in the following cycle; done[0] at grant+MUL_CYCLES+3; result 15.
REQ-038 All four req after reset with operands 15x15, 0x12, 1x2 and 92x75 -> grant order 0,1,2,3; results 225, 0, 2, 6900.
REQ-039 req[1] and req[3] re-raised after each done -> grants alternate 1,3,1,3 with no starvation.
REQ-040 127x127 -> result 16129; no overflow.
REQ-041 rst_n low during WAIT -> outputs 0 at once, mul_rst=1, no done; after release with req[2] and req[0] high -> grant[0] first.
